vga_tile_render: RTL and testbench

VGA_TILE_RENDER -- requirements
Module: vga_tile_render

---
 rtl/vga_pkg.sv | 22 ++
 rtl/tile_palette.sv | 32 +++
 rtl/vga_tile_render.sv | 143 ++++++++++++++
 tb/tb_vga_tile_render.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing/geometry constants and the sprite register type for the tile renderer.
package vga_pkg;

    localparam int H_START_DEF = 143;
    localparam int V_START_DEF = 32;
    localparam int MAP_COLS    = 40;
    localparam int MAP_ROWS    = 30;
    localparam int TILE_SHIFT  = 4;
    localparam int PIPE_LAT    = 3;
    localparam int SPR_SIZE    = 16;
    localparam int SPR_X_MAX   = 624;
    localparam int SPR_Y_MAX   = 464;

    typedef struct packed {
        logic       en;
        logic [9:0] x;
        logic [8:0] y;
    } sprite_t;

    localparam sprite_t SPR_RESET = '{en: 1'b0, x: 10'd312, y: 9'd232};

endpackage

// File: rtl/tile_palette.sv
// Fixed 16-entry EGA-style tile palette, combinational lookup.
module tile_palette
    import vga_pkg::*;
(
    input  logic [3:0]  code,
    output logic [11:0] color
);

    always_comb begin
        color = 12'h000;
        case (code)
            4'd0:  color = 12'h000;
            4'd1:  color = 12'h00A;
            4'd2:  color = 12'h0A0;
            4'd3:  color = 12'h0AA;
            4'd4:  color = 12'hA00;
            4'd5:  color = 12'hA0A;
            4'd6:  color = 12'hA50;
            4'd7:  color = 12'hAAA;
            4'd8:  color = 12'h555;
            4'd9:  color = 12'h55F;
            4'd10: color = 12'h5F5;
            4'd11: color = 12'h5FF;
            4'd12: color = 12'hF55;
            4'd13: color = 12'hF5F;
            4'd14: color = 12'hFF5;
            4'd15: color = 12'hFFF;
            default: color = 12'h000;
        endcase
    end

endmodule

// File: rtl/vga_tile_render.sv
// Three-stage tile-map renderer with one double-buffered 16x16 sprite overlay.
module vga_tile_render
    import vga_pkg::*;
#(
    parameter int          H_START   = H_START_DEF,
    parameter int          V_START   = V_START_DEF,
    parameter logic [11:0] SPR_COLOR = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        valid_in,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic [10:0] map_addr,
    input  logic [3:0]  map_data,
    input  logic        spr_we,
    input  logic        spr_en,
    input  logic [9:0]  spr_x,
    input  logic [8:0]  spr_y,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hs_out,
    output logic        vs_out,
    output logic        valid_out
);

    function automatic sprite_t clamp_sprite(input logic en, input logic [9:0] x, input logic [8:0] y);
        sprite_t s;
        s.en = en;
        s.x  = (x > 10'(SPR_X_MAX)) ? 10'(SPR_X_MAX) : x;
        s.y  = (y > 9'(SPR_Y_MAX))  ? 9'(SPR_Y_MAX)  : y;
        return s;
    endfunction

    logic [9:0]  px_s0, py_s0;
    logic [5:0]  col_s0;
    logic [4:0]  row_s0;
    logic [10:0] addr_s0;
    logic        frame_start;

    logic [9:0]  px_p1, py_p1, px_p2, py_p2;
    logic        vld_p1, hs_p1, vs_p1;
    logic        vld_p2, hs_p2, vs_p2;
    logic [11:0] rgb_p3;
    logic        vld_p3, hs_p3, vs_p3;

    sprite_t     spr_act, spr_pend;
    logic        pend_flag;
    logic [11:0] pal_color;
    logic [10:0] px_w, py_w, sx_lo, sx_hi, sy_lo, sy_hi;
    logic        hit;

    assign px_s0   = h_cnt - 10'(H_START);
    assign py_s0   = v_cnt - 10'(V_START);
    assign col_s0  = px_s0[9:TILE_SHIFT];
    assign row_s0  = py_s0[8:TILE_SHIFT];
    // row*40 as shift-add: row*32 + row*8
    assign addr_s0 = ({6'd0, row_s0} << 5) + ({6'd0, row_s0} << 3) + {5'd0, col_s0};
    assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);

    // Sprite updates only land at frame start so a frame never shows two positions.
    always_ff @(posedge clk) begin
        if (rst) begin
            spr_act   <= SPR_RESET;
            spr_pend  <= SPR_RESET;
            pend_flag <= 1'b0;
        end else begin
            if (frame_start && pend_flag)
                spr_act <= spr_pend;
            if (spr_we) begin
                spr_pend  <= clamp_sprite(spr_en, spr_x, spr_y);
                pend_flag <= 1'b1;
            end else if (frame_start) begin
                pend_flag <= 1'b0;
            end
        end
    end

    tile_palette u_palette (
        .code  (map_data),
        .color (pal_color)
    );

    // 11-bit compare so x+15 / y+15 cannot wrap back into range
    assign px_w  = {1'b0, px_p2};
    assign py_w  = {1'b0, py_p2};
    assign sx_lo = {1'b0, spr_act.x};
    assign sx_hi = sx_lo + 11'(SPR_SIZE - 1);
    assign sy_lo = {2'b0, spr_act.y};
    assign sy_hi = sy_lo + 11'(SPR_SIZE - 1);
    assign hit   = spr_act.en && (px_w >= sx_lo) && (px_w <= sx_hi)
                               && (py_w >= sy_lo) && (py_w <= sy_hi);

    always_ff @(posedge clk) begin
        if (rst) begin
            map_addr <= '0;
            px_p1    <= '0;
            py_p1    <= '0;
            vld_p1   <= 1'b0;
            hs_p1    <= 1'b1;
            vs_p1    <= 1'b1;
            px_p2    <= '0;
            py_p2    <= '0;
            vld_p2   <= 1'b0;
            hs_p2    <= 1'b1;
            vs_p2    <= 1'b1;
            rgb_p3   <= '0;
            vld_p3   <= 1'b0;
            hs_p3    <= 1'b1;
            vs_p3    <= 1'b1;
        end else begin
            // stage 1: position and tile-map address
            map_addr <= valid_in ? addr_s0 : '0;
            px_p1    <= px_s0;
            py_p1    <= py_s0;
            vld_p1   <= valid_in;
            hs_p1    <= hs_in;
            vs_p1    <= vs_in;
            // stage 2: tile RAM registers map_data alongside these
            px_p2    <= px_p1;
            py_p2    <= py_p1;
            vld_p2   <= vld_p1;
            hs_p2    <= hs_p1;
            vs_p2    <= vs_p1;
            // stage 3: colour select
            rgb_p3   <= !vld_p2 ? 12'h000 : (hit ? SPR_COLOR : pal_color);
            vld_p3   <= vld_p2;
            hs_p3    <= hs_p2;
            vs_p3    <= vs_p2;
        end
    end

    assign red       = rgb_p3[11:8];
    assign green     = rgb_p3[7:4];
    assign blue      = rgb_p3[3:0];
    assign hs_out    = hs_p3;
    assign vs_out    = vs_p3;
    assign valid_out = vld_p3;

endmodule

// File: tb/tb_vga_tile_render.sv
// Directed scoreboard bench for vga_tile_render with a behavioural tile RAM.
module tb_vga_tile_render;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  h_cnt, v_cnt;
    logic        valid_in, hs_in, vs_in;
    logic [10:0] map_addr;
    logic [3:0]  map_data;
    logic        spr_we, spr_en;
    logic [9:0]  spr_x;
    logic [8:0]  spr_y;
    logic [3:0]  red, green, blue;
    logic        hs_out, vs_out, valid_out;

    always #5 clk = ~clk;

    vga_tile_render dut (
        .clk       (clk),
        .rst       (rst),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .valid_in  (valid_in),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .map_addr  (map_addr),
        .map_data  (map_data),
        .spr_we    (spr_we),
        .spr_en    (spr_en),
        .spr_x     (spr_x),
        .spr_y     (spr_y),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .valid_out (valid_out)
    );

    logic [3:0] mem [0:2047];
    always_ff @(posedge clk) map_data <= mem[map_addr];

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        vld;
    } exp_t;

    exp_t        q[$];
    logic [11:0] pal [16];
    int          checks = 0;
    int          errors = 0;
    int          exp_addr;
    bit          addr_pend;
    bit          m_en, p_en, m_pf;
    int          m_x, m_y, p_x, p_y;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_x = 312; m_y = 232;
        p_en = 0; p_x = 312; p_y = 232;
        m_pf = 0;
    endtask

    task automatic step(input int h, input int v, input bit vin, input bit hs, input bit vs,
                        input bit we = 1'b0, input bit en = 1'b0, input int x = 0, input int y = 0);
        exp_t e;
        int   px, py, a;
        if (q.size() == 3) begin
            e = q.pop_front();
            chk("rgb", {red, green, blue}, e.rgb);
            chk("hs_out", 12'(hs_out), 12'(e.hs));
            chk("vs_out", 12'(vs_out), 12'(e.vs));
            chk("valid_out", 12'(valid_out), 12'(e.vld));
        end
        if (addr_pend) chk("map_addr", 12'(map_addr), 12'(exp_addr));
        h_cnt = h[9:0]; v_cnt = v[9:0];
        valid_in = vin; hs_in = hs; vs_in = vs;
        spr_we = we; spr_en = en; spr_x = x[9:0]; spr_y = y[8:0];
        px = (h - 143) & 1023;
        py = (v - 32) & 1023;
        a  = ((py >> 4) & 31) * 40 + ((px >> 4) & 63);
        exp_addr  = vin ? a : 0;
        addr_pend = 1;
        e.hs = hs; e.vs = vs; e.vld = vin;
        if (!vin)
            e.rgb = 12'h000;
        else if (m_en && px >= m_x && px <= m_x + 15 && py >= m_y && py <= m_y + 15)
            e.rgb = 12'hFFF;
        else
            e.rgb = pal[mem[a]];
        q.push_back(e);
        if (h == 0 && v == 0) begin
            if (m_pf) begin m_en = p_en; m_x = p_x; m_y = p_y; end
            m_pf = 0;
        end
        if (we) begin
            p_en = en;
            p_x  = (x > 624) ? 624 : x;
            p_y  = (y > 464) ? 464 : y;
            m_pf = 1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(400, 600, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                step(143 + x, 32 + y, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        exp_t e;
        rst = 1'b1; valid_in = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
        h_cnt = 10'd300; v_cnt = 10'd100; spr_we = 1'b0;
        @(negedge clk);
        chk("rst_map_addr", 12'(map_addr), 12'h000);
        chk("rst_rgb", {red, green, blue}, 12'h000);
        chk("rst_valid_out", 12'(valid_out), 12'h000);
        chk("rst_hs_out", 12'(hs_out), 12'h001);
        chk("rst_vs_out", 12'(vs_out), 12'h001);
        rst = 1'b0;
        q.delete();
        e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1; e.vld = 1'b0;
        q.push_back(e);
        q.push_back(e);
        addr_pend = 0;
        model_reset();
    endtask

    initial begin
        pal = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
                12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
        for (int i = 0; i < 2048; i++) mem[i] = 4'(i % 15);
        mem[83] = 4'd15;
        mem[0]  = 4'd15;
        rst = 1'b1; h_cnt = '0; v_cnt = '0; valid_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        spr_we = 1'b0; spr_en = 1'b0; spr_x = '0; spr_y = '0;
        addr_pend = 0;
        model_reset();
        repeat (3) @(negedge clk);
        do_reset();

        // tile 83 holds code 15, sprite disabled
        step(143 + 48, 32 + 32, 1'b1, 1'b1, 1'b1);
        step(143 + 50, 32 + 33, 1'b1, 1'b0, 1'b1);
        step(143 + 64, 32 + 32, 1'b1, 1'b1, 1'b0);
        step(143 + 48, 32 + 32, 1'b0, 1'b0, 1'b0);
        step(143 + 48, 32 + 32, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++)
            step($urandom_range(143, 782), $urandom_range(32, 511), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle(3);

        // mid-frame write must wait for the next frame start
        step(300, 200, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 100, 50);
        scan(96, 120, 48, 68);
        idle(3);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        idle(2);
        scan(96, 120, 48, 68);
        idle(3);

        // clamped write, then a second write landing in the frame-start cycle
        step(300, 200, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 700, 500);
        idle(3);
        step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 200, 100);
        idle(2);
        scan(618, 639, 460, 479);
        scan(197, 217, 98, 118);
        idle(3);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        idle(2);
        scan(197, 217, 98, 118);
        scan(618, 639, 460, 479);

        // reset mid-line, then only fresh inputs may appear
        step(143 + 200, 32 + 100, 1'b1, 1'b0, 1'b0);
        step(143 + 201, 32 + 100, 1'b1, 1'b0, 1'b0);
        do_reset();
        step(143 + 48, 32 + 32, 1'b1, 1'b0, 1'b1);
        scan(197, 206, 98, 101);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
